// File: rtl/mc_core_seq.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the NPC single-issue RV core.
// Optional wait-state watchdog: define CTRL_TIMEOUT_EN to enable the TIMEOUT-cycle limit.
module mc_core_seq #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    output logic             inst_latch,
    input  logic             dec_reg_wen,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_is_ebreak,
    input  logic             dec_illegal,
    output logic             dmem_req_valid,
    output logic             dmem_req_wen,
    input  logic             dmem_req_ready,
    input  logic             dmem_rsp_valid,
    output logic             rf_wen,
    output logic             pc_wen,
    output logic             halt,
    output logic             err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_MREQ  = 3'd3,
        S_MWAIT = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_norm;
    state_t           w_next;
    logic             r_mem_wen;
    logic             r_rf_wr;
    logic             r_halt;
    logic             r_err;
    logic [CNT_W-1:0] r_retire_cnt;

    always_comb begin
        // NOTE: default assigned first so every path drives w_norm and no latch is inferred.
        w_norm = r_state;
        case (r_state)
            S_FETCH: if (imem_req_ready) w_norm = S_IWAIT;
            S_IWAIT: if (imem_rsp_valid) w_norm = S_EXEC;
            S_EXEC: begin
                if (dec_is_ebreak)                                 w_norm = S_HALT;
                else if (dec_illegal || (dec_is_load && dec_is_store)) w_norm = S_ERR;
                else if (dec_is_load || dec_is_store)              w_norm = S_MREQ;
                else                                               w_norm = S_WB;
            end
            S_MREQ:  if (dmem_req_ready) w_norm = S_MWAIT;
            S_MWAIT: if (dmem_rsp_valid) w_norm = S_WB;
            S_WB:    w_norm = S_FETCH;
            S_HALT:  w_norm = S_HALT;
            S_ERR:   w_norm = S_ERR;
            default: w_norm = S_ERR;
        endcase
    end

`ifdef CTRL_TIMEOUT_EN
    localparam int                WCNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    logic [WCNT_W-1:0] r_wait_cnt;
    logic              w_wait_state;
    logic              w_hs;
    logic              w_timeout;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_IWAIT) ||
                          (r_state == S_MREQ)  || (r_state == S_MWAIT);
    assign w_hs = ((r_state == S_FETCH) && imem_req_ready) ||
                  ((r_state == S_IWAIT) && imem_rsp_valid) ||
                  ((r_state == S_MREQ)  && dmem_req_ready) ||
                  ((r_state == S_MWAIT) && dmem_rsp_valid);
    // A handshake in the final allowed cycle beats the watchdog.
    assign w_timeout = w_wait_state && !w_hs && (r_wait_cnt == WCNT_LAST);
    assign w_next    = w_timeout ? S_ERR : w_norm;

    always_ff @(posedge clk) begin
        if (rst)                  r_wait_cnt <= '0;
        else if (w_next != r_state) r_wait_cnt <= '0;
        else if (w_wait_state)    r_wait_cnt <= r_wait_cnt + 1'b1;
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_next           = w_norm;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state      <= S_FETCH;
            r_mem_wen    <= 1'b0;
            r_rf_wr      <= 1'b0;
            r_halt       <= 1'b0;
            r_err        <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC) begin
                r_mem_wen <= dec_is_store;
                r_rf_wr   <= (dec_is_load || dec_is_store) ? dec_is_load : dec_reg_wen;
            end
            if (r_state == S_WB) r_retire_cnt <= r_retire_cnt + 1'b1;
            if ((w_next == S_HALT) || (w_next == S_ERR)) r_halt <= 1'b1;
            if (w_next == S_ERR) r_err <= 1'b1;
        end
    end

    // Pulses and valids are masked while rst is high so an abandoned instruction never commits.
    assign imem_req_valid = !rst && (r_state == S_FETCH);
    assign inst_latch     = !rst && (r_state == S_IWAIT) && imem_rsp_valid;
    assign dmem_req_valid = !rst && (r_state == S_MREQ);
    assign dmem_req_wen   = r_mem_wen;
    assign pc_wen         = !rst && (r_state == S_WB);
    assign rf_wen         = !rst && (r_state == S_WB) && r_rf_wr;
    assign halt           = r_halt;
    assign err            = r_err;
    assign state_o        = r_state;
    assign retire_cnt     = r_retire_cnt;

endmodule

// File: tb/tb_mc_core_seq.sv
// Randomized scoreboard bench for mc_core_seq: a memory/decoder driver issues instructions
// and pushes expected commits; a negedge monitor pops and compares whenever the DUT commits.
module tb_mc_core_seq;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_EBREAK, K_ILLEGAL, K_BOTH} kind_e;
    typedef struct { bit rf; int cnt; } wb_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             imem_req_valid, imem_req_ready, imem_rsp_valid, inst_latch;
    logic             dec_reg_wen, dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal;
    logic             dmem_req_valid, dmem_req_wen, dmem_req_ready, dmem_rsp_valid;
    logic             rf_wen, pc_wen, halt, err;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retire_cnt;

    wb_t wb_q[$];
    bit  mem_q[$];
    wb_t mon_e;
    int  n_checks = 0;
    int  n_errors = 0;
    int  exp_cnt  = 0;
    int  n_fetch  = 0;
    int  n_latch  = 0;

    mc_core_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .inst_latch(inst_latch),
        .dec_reg_wen(dec_reg_wen), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_is_ebreak(dec_is_ebreak), .dec_illegal(dec_illegal),
        .dmem_req_valid(dmem_req_valid), .dmem_req_wen(dmem_req_wen),
        .dmem_req_ready(dmem_req_ready), .dmem_rsp_valid(dmem_rsp_valid),
        .rf_wen(rf_wen), .pc_wen(pc_wen), .halt(halt), .err(err),
        .state_o(state_o), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_dec();
        dec_reg_wen   = 1'($urandom);
        dec_is_load   = 1'($urandom);
        dec_is_store  = 1'($urandom);
        dec_is_ebreak = 1'($urandom);
        dec_illegal   = 1'($urandom);
    endtask

    task automatic push_wb(input bit rf);
        wb_q.push_back(wb_t'{rf: rf, cnt: exp_cnt % CNT_MOD});
        exp_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        scramble_dec();
        #1;
        check("rst_pulses", {imem_req_valid, inst_latch, dmem_req_valid, rf_wen, pc_wen}, 0);
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        check("rst_state", state_o, 0);
        check("rst_retire_cnt", retire_cnt, 0);
        check("rst_halt_err", {halt, err}, 0);
    endtask

    // Plays memory and decoder for one instruction; returns with the core back in FETCH
    // (normal), in HALT/ERR (terminal kinds), or just out of reset (abort_mw).
    task automatic do_instr(input kind_e kind, input bit rwen, input int dmax,
                            input int req_dly, input bit abort_mw);
        int d;
        bit is_mem;
        is_mem = (kind == K_LOAD) || (kind == K_STORE);
        n_fetch++;
        d = $urandom_range(0, dmax);
        for (int n = 0; n <= d; n++) begin
            imem_req_ready = (n == d);
            imem_rsp_valid = 1'($urandom);
            #1;
            check("imem_req_valid", imem_req_valid, 1);
            tick();
        end
        imem_req_ready = 1'b0;
        d = $urandom_range(0, dmax);
        for (int n = 0; n <= d; n++) begin
            imem_rsp_valid = (n == d);
            #1;
            check("inst_latch", inst_latch, (n == d));
            tick();
        end
        imem_rsp_valid = 1'b0;
        dec_reg_wen   = rwen;
        dec_is_load   = (kind == K_LOAD) || (kind == K_BOTH);
        dec_is_store  = (kind == K_STORE) || (kind == K_BOTH);
        dec_is_ebreak = (kind == K_EBREAK);
        dec_illegal   = (kind == K_ILLEGAL) || ((kind == K_EBREAK) && 1'($urandom));
        if (kind == K_ALU) push_wb(rwen);
        if (is_mem && !abort_mw) push_wb(kind == K_LOAD);
        if (is_mem) mem_q.push_back(kind == K_STORE);
        tick();
        scramble_dec();
        case (kind)
            K_EBREAK: begin
                check("ebreak_state", state_o, 6);
                check("ebreak_halt_err", {halt, err}, 2'b10);
            end
            K_ILLEGAL, K_BOTH: begin
                check("err_state", state_o, 7);
                check("err_halt_err", {halt, err}, 2'b11);
            end
            K_ALU: begin
                #1;
                check("alu_wb_timing", pc_wen, 1);
                tick();
            end
            default: begin
                d = (req_dly >= 0) ? req_dly : $urandom_range(0, dmax);
                for (int n = 0; n <= d; n++) begin
                    dmem_req_ready = (n == d);
                    #1;
                    check("dmem_req_valid", dmem_req_valid, 1);
                    tick();
                end
                dmem_req_ready = 1'b0;
                if (abort_mw) begin
                    tick();
                    rst = 1'b1;
                    dmem_rsp_valid = 1'b1;
                    #1;
                    check("abort_no_commit", {rf_wen, pc_wen}, 0);
                    tick();
                    rst = 1'b0;
                    dmem_rsp_valid = 1'b0;
                    exp_cnt = 0;
                    #1;
                    check("abort_state", state_o, 0);
                    check("abort_pc_wen", pc_wen, 0);
                    check("abort_retire_cnt", retire_cnt, 0);
                end else begin
                    d = $urandom_range(0, dmax);
                    for (int n = 0; n <= d; n++) begin
                        dmem_rsp_valid = (n == d);
                        tick();
                    end
                    dmem_rsp_valid = 1'b0;
                    #1;
                    check("mem_wb_timing", pc_wen, 1);
                    tick();
                end
            end
        endcase
    endtask

    // Monitor: pops expected commits whenever the DUT presents a data request or a writeback.
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req_valid) begin
                if (mem_q.size() == 0) check("dmem_req_unexpected", 1, 0);
                else begin
                    check("dmem_req_wen", dmem_req_wen, mem_q[0]);
                    if (dmem_req_ready) void'(mem_q.pop_front());
                end
            end
            if (pc_wen) begin
                if (wb_q.size() == 0) check("pc_wen_unexpected", 1, 0);
                else begin
                    mon_e = wb_q.pop_front();
                    check("wb_rf_wen", rf_wen, mon_e.rf);
                    check("wb_retire_cnt", retire_cnt, mon_e.cnt);
                end
            end else if (rf_wen) begin
                check("rf_wen_without_pc_wen", 1, 0);
            end
            if (inst_latch) n_latch++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not reach its summary");
        $fatal(1, "time limit");
    end

    initial begin
        int bad;
        kind_e k;
        do_reset();

        // addi with zero-wait memory: 4 cycles FETCH to FETCH
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1;
        dec_reg_wen = 1'b1; dec_is_load = 1'b0; dec_is_store = 1'b0;
        dec_is_ebreak = 1'b0; dec_illegal = 1'b0;
        push_wb(1'b1);
        n_fetch++;
        #1;
        check("addi_c0", {imem_req_valid, state_o}, {1'b1, 3'd0});
        tick(); #1;
        check("addi_c1", {inst_latch, state_o}, {1'b1, 3'd1});
        tick(); #1;
        check("addi_c2", state_o, 2);
        tick(); #1;
        check("addi_c3", {rf_wen, pc_wen, state_o}, {2'b11, 3'd5});
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        #1;
        check("addi_c4", {state_o, retire_cnt}, {3'd0, 4'd1});

        do_instr(K_LOAD, 1'b0, 0, 3, 1'b0);
        do_instr(K_STORE, 1'b1, 0, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       k = K_ALU;
                1:       k = K_LOAD;
                default: k = K_STORE;
            endcase
            do_instr(k, 1'($urandom), 3, -1, 1'b0);
        end

        do_instr(K_EBREAK, 1'($urandom), 2, -1, 1'b0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            imem_req_ready = 1'($urandom); imem_rsp_valid = 1'($urandom);
            dmem_req_ready = 1'($urandom); dmem_rsp_valid = 1'($urandom);
            scramble_dec();
            #1;
            if (imem_req_valid || dmem_req_valid || pc_wen || !halt || err || state_o != 3'd6) bad++;
            tick();
        end
        check("halt_sticky_violations", bad, 0);
        check("halt_retire_cnt", retire_cnt, exp_cnt % CNT_MOD);
        do_reset();

        for (int t = 0; t < 2; t++) begin
            do_instr(K_ALU, 1'b1, 1, -1, 1'b0);
            do_instr((t == 0) ? K_ILLEGAL : K_BOTH, 1'($urandom), 1, -1, 1'b0);
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                imem_req_ready = 1'($urandom); dmem_req_ready = 1'($urandom);
                scramble_dec();
                #1;
                if (imem_req_valid || dmem_req_valid || pc_wen || !halt || !err || state_o != 3'd7) bad++;
                tick();
            end
            check("err_sticky_violations", bad, 0);
            do_reset();
        end

        do_instr(K_STORE, 1'b1, 1, -1, 1'b0);
        do_instr(K_LOAD, 1'b1, 1, -1, 1'b1);
        do_instr(K_ALU, 1'b1, 1, -1, 1'b0);
        do_instr(K_LOAD, 1'b1, 1, -1, 1'b0);

`ifdef CTRL_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        #1;
        check("timeout_before_limit", state_o, 0);
        tick(); #1;
        check("timeout_err", {state_o, err, halt}, {3'd7, 2'b11});
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #1;
        check("timeout_hs_wins", {state_o, err}, {3'd1, 1'b0});
        do_reset();
`endif

        tick();
        tick();
        check("wb_queue_drained", wb_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        check("inst_latch_count", n_latch, n_fetch);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_core_seq.md
Name: mc_core_seq

Overview:
- Multi-cycle sequencer for the NPC single-issue RV core.
- Sequences instruction fetch, decode/execute, data memory access and writeback through handshaked instruction and data memory ports.
- Consumes the level-decoded control flags from the instruction decoder.
- Gates register-file write and PC update so each architectural state change happens exactly once per instruction.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TIMEOUT, 256, max cycles allowed in any memory wait state (used only with CTRL_TIMEOUT_EN).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  fetch request accepted.
- imem_rsp_valid  in  1  instruction data valid.
- inst_latch  out  1  one-cycle pulse: capture the instruction register.
- dec_reg_wen  in  1  RegWEn from the decoder.
- dec_is_load  in  1  current instruction is a load.
- dec_is_store  in  1  current instruction is a store.
- dec_is_ebreak  in  1  current instruction is ebreak.
- dec_illegal  in  1  unknown immediate type / opcode.
- dmem_req_valid  out  1  data request.
- dmem_req_wen  out  1  1 = store, 0 = load; valid with dmem_req_valid.
- dmem_req_ready  in  1  data request accepted.
- dmem_rsp_valid  in  1  data response / store acknowledge.
- rf_wen  out  1  register-file write enable, one-cycle pulse.
- pc_wen  out  1  PC update enable, one-cycle pulse.
- halt  out  1  sticky, core stopped.
- err  out  1  sticky error.
- state_o  out  3  current state encoding (debug).
- retire_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- States and encodings: FETCH=0, IWAIT=1, EXEC=2, MREQ=3, MWAIT=4, WB=5, HALT=6, ERR=7.
- Reset: state=FETCH; retire_cnt=0; halt=0; err=0. All pulse and valid outputs are 0 during the reset cycle.
- Reset taken mid-operation in any state abandons the instruction; no rf_wen or pc_wen is issued.
- FETCH:
  - imem_req_valid=1, held until imem_req_ready.
  - On ready -> IWAIT.
  - imem_rsp_valid is ignored in FETCH.
- IWAIT:
  - On imem_rsp_valid, inst_latch=1 in the same cycle (Mealy) -> EXEC.
- EXEC (exactly one cycle):
  - Decoder inputs are sampled only in this state.
  - Priority: dec_is_ebreak -> HALT; else dec_illegal, or load and store both set -> ERR; else load or store -> MREQ (latch wen=dec_is_store, latch rf write = dec_is_load); else -> WB (latch rf write = dec_reg_wen).
- MREQ:
  - dmem_req_valid=1; dmem_req_wen = latched value, stable while valid.
  - On dmem_req_ready -> MWAIT.
- MWAIT:
  - On dmem_rsp_valid -> WB. Stores also wait for the acknowledge.
- WB (one cycle):
  - pc_wen=1; rf_wen = latched rf write flag (always 0 for stores).
  - retire_cnt += 1, wrapping modulo 2^CNT_W.
  - -> FETCH.
- HALT:
  - halt=1, sticky until rst.
  - No memory requests; pc_wen=0; retire_cnt does not count the ebreak.
- ERR:
  - err=1 and halt=1, both sticky until rst.
- Latency with zero-wait memory (ready/rsp asserted on first opportunity):
  - ALU/jump instruction: 4 cycles FETCH->FETCH.
  - Load/store: 6 cycles.
- state_o equals the registered state.

Optional Feature:
- Macro: CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every state change and increments each cycle spent in FETCH, IWAIT, MREQ or MWAIT.
  - When the counter reaches TIMEOUT with no handshake completing, next state=ERR.
  - A handshake in the same cycle as the timeout wins: the normal transition is taken.
- Undefined:
  - No counter is present; wait states may stall indefinitely.
  - err is set only via the illegal path.

Test Plan:
- addi, zero-wait memory: rst 2 cycles, then ready and rsp held high -> inst_latch at cycle 1, rf_wen=1 and pc_wen=1 at cycle 3, state back to 0 at cycle 4, retire_cnt=1.
- Load, dmem_req_ready delayed 3 cycles: dmem_req_valid=1 and wen=0 held stable for 4 cycles -> rf_wen=1 one cycle after dmem_rsp_valid.
- Store: dmem_req_wen=1 with dec_reg_wen=1 -> WB has rf_wen=0 and pc_wen=1.
- ebreak (0x00100073 decoded, dec_is_ebreak=1) -> state 6, halt=1 persists 100 cycles, no imem_req_valid, retire_cnt unchanged; rst -> state 0, halt=0.
- Illegal (dec_illegal=1), and separately load+store both set -> state 7, err=1, halt=1; rst asserted mid-MWAIT -> next cycle FETCH with no pc_wen.
- CTRL_TIMEOUT_EN with TIMEOUT=8: imem_req_ready held low -> ERR entered after 8 cycles in FETCH; ready asserted on the 8th cycle -> IWAIT, err stays 0.
